// File: rtl/conv_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional code (encoder and decoder side).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: constraint length, default generator polynomials, tail length,
// trellis state type, encoder FSM encoding and the registered code pair struct.
package conv_pkg;

  localparam int K        = 3;
  localparam int TAIL_LEN = K - 1;

  // Bit K-1 of each generator taps the current input bit.
  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  // Trellis state: the K-1 most recent prior input bits, MSB newest.
  typedef logic [K-2:0] trellis_t;

  typedef enum logic [1:0] {
    ENC_DATA  = 2'd0,
    ENC_TAIL1 = 2'd1,
    ENC_TAIL2 = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic cx0;
    logic cx1;
    logic last;
  } code_pair_t;

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step of the convolutional code: code pair and next state for input u.
// Latency: combinational.
// Backpressure: none (pure function of u and sr).
//
// Ports: u (input bit), sr (current trellis state), cx0/cx1 (code bits from
// G0/G1), next_sr (state after shifting u in).
module conv_enc_step
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0 = G0_DEF,
  parameter logic [K-1:0] G1 = G1_DEF
) (
  input  logic     u,
  input  trellis_t sr,
  output logic     cx0,
  output logic     cx1,
  output trellis_t next_sr
);

  logic [K-1:0] w;

  assign w       = {u, sr};
  assign cx0     = ^(w & G0);
  assign cx1     = ^(w & G1);
  assign next_sr = {u, sr[K-2:1]};

endmodule

// File: rtl/conv_enc.sv
// Rate-1/2 K=3 convolutional encoder, one info bit in and one registered code pair out per handshake.
// Latency: 1 cycle (bit accepted at edge N -> its pair valid after edge N); 1 pair/cycle sustained.
// Backpressure: single output register, in_ready = slot free (combinational on out_ready); pair held while stalled.
//
// Ports: clk, reset (sync, active-high); in_valid/in_ready/in_bit/in_last
// (info bit stream); out_valid/out_ready/cx0/cx1/out_last (code pair stream);
// frame_cnt (completed frames, wraps).
// Build option CONV_ENC_TAIL_EN: append two zero tail pairs after each in_last
// bit, flag out_last on the second one and return the trellis to state 0.
// Without it, out_last follows in_last and the trellis state carries across frames.
module conv_enc
  import conv_pkg::*;
#(
  parameter logic [K-1:0] G0    = G0_DEF,
  parameter logic [K-1:0] G1    = G1_DEF,
  parameter int           CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cx0,
  output logic             cx1,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt
);

  code_pair_t out_q;
  trellis_t   sr;
  trellis_t   step_sr;
  logic       step_cx0;
  logic       step_cx1;
  logic       out_free;
  logic       accept;
  logic       load;
  logic       load_last;
  logic       sr_clear;
  logic       u;

  // The output slot can take a new pair if it is empty or drains this edge.
  assign out_free = !out_valid || out_ready;

`ifdef CONV_ENC_TAIL_EN
  localparam logic [1:0] ST_DATA  = ENC_DATA;
  localparam logic [1:0] ST_TAIL1 = ENC_TAIL1;
  localparam logic [1:0] ST_TAIL2 = ENC_TAIL2;

  logic [1:0] state;
  logic       inject;

  assign in_ready  = (state == ST_DATA) && out_free;
  assign accept    = in_valid && in_ready;
  assign inject    = (state != ST_DATA) && out_free;
  assign load      = accept || inject;
  // Tail steps push zeros; accept is only possible in DATA.
  assign u         = accept & in_bit;
  assign load_last = (state == ST_TAIL2);
  // After two zero steps the state is already 00; clearing explicitly keeps
  // the decoder's start-in-state-0 guarantee independent of the polynomials.
  assign sr_clear  = (state == ST_TAIL2);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_DATA;
    end else begin
      case (state)
        ST_DATA:  if (accept && in_last) state <= ST_TAIL1;
        ST_TAIL1: if (inject) state <= ST_TAIL2;
        ST_TAIL2: if (inject) state <= ST_DATA;
        default:  state <= ST_DATA;
      endcase
    end
  end
`else
  assign in_ready  = out_free;
  assign accept    = in_valid && in_ready;
  assign load      = accept;
  assign u         = in_bit;
  assign load_last = in_last;
  assign sr_clear  = 1'b0;
`endif

  conv_enc_step #(
    .G0 (G0),
    .G1 (G1)
  ) u_step (
    .u       (u),
    .sr      (sr),
    .cx0     (step_cx0),
    .cx1     (step_cx1),
    .next_sr (step_sr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (out_valid && out_ready && out_q.last) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (load) begin
        out_q     <= '{cx0: step_cx0, cx1: step_cx1, last: load_last};
        out_valid <= 1'b1;
        sr        <= sr_clear ? trellis_t'(0) : step_sr;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign cx0      = out_q.cx0;
  assign cx1      = out_q.cx1;
  assign out_last = out_q.last;

endmodule

// File: tb/tb_conv_enc.sv
// Self-checking bench for conv_enc: directed frames, scoreboard of expected code pairs.
// Latency: n/a (testbench).
// Backpressure: out_ready driven by the directed sequence.
module tb_conv_enc;

  localparam int CNT_W = 4;
`ifdef CONV_ENC_TAIL_EN
  localparam int GAP = 3;
`else
  localparam int GAP = 1;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_bit = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             cx0;
  logic             cx1;
  logic             out_last;
  logic [CNT_W-1:0] frame_cnt;

  conv_enc #(
    .G0    (3'b111),
    .G1    (3'b101),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cx0       (cx0),
    .cx1       (cx1),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entries are {cx0, cx1, last}.
  logic [2:0] exp_q[$];
  logic [1:0] m_sr = 2'b00;
  int         m_frames = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n_pairs = 0;
  int         last_acc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoder with the default polynomials written out directly.
  task automatic model_push(input logic b, input logic l);
    logic c0, c1;
    c0   = b ^ m_sr[1] ^ m_sr[0];
    c1   = b ^ m_sr[0];
    m_sr = {b, m_sr[1]};
`ifdef CONV_ENC_TAIL_EN
    exp_q.push_back({c0, c1, 1'b0});
    if (l) begin
      for (int i = 0; i < 2; i++) begin
        c0   = m_sr[1] ^ m_sr[0];
        c1   = m_sr[0];
        m_sr = {1'b0, m_sr[1]};
        exp_q.push_back({c0, c1, (i == 1)});
      end
    end
`else
    exp_q.push_back({c0, c1, l});
`endif
  endtask

  // Compare every transferred pair against the scoreboard head.
  always @(negedge clk) begin
    if (out_valid && out_ready && !reset) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL spurious_pair: observed %b%b last=%b expected no pair", cx0, cx1, out_last);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        check($sformatf("pair%0d", n_pairs), {cx0, cx1, out_last}, e);
        n_pairs++;
        if (e[0]) m_frames++;
      end
    end
  end

  task automatic send_bit(input logic b, input logic l);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $error("FAIL accept_timeout: observed in_ready=0 for %0d cycles expected 1", n);
    end else begin
      last_acc = cyc;
      model_push(b, l);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_sr     = 2'b00;
    m_frames = 0;
  endtask

  initial begin
    logic [2:0] held;
    int         a, b, c;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_cx0", cx0, 0);
    check("rst_cx1", cx1, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);

    // Frame 1,0,1,1 with the sink always ready
    send_bit(1, 0);
    send_bit(0, 0);
    send_bit(1, 0);
    send_bit(1, 1);
    drain();
    check("frame_cnt_a", frame_cnt, m_frames % (1 << CNT_W));

    // Same frame, sink stalls for 3 cycles on the second pair
    send_bit(1, 0);
    send_bit(0, 0);
    held      = exp_q[0];
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b1;
    in_last   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_pair_held", {cx0, cx1, out_last}, held);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send_bit(1, 0);
    send_bit(1, 1);
    drain();
    check("frame_cnt_b", frame_cnt, m_frames % (1 << CNT_W));

    // From reset: frame 1,0,1,1 then a frame starting with 1
    do_reset();
    send_bit(1, 0);
    send_bit(0, 0);
    send_bit(1, 0);
    send_bit(1, 1);
    send_bit(1, 1);
    drain();
    check("frame_cnt_c", frame_cnt, m_frames % (1 << CNT_W));

    // Abort a frame by reset with its last pair still pending
    do_reset();
    send_bit(1, 0);
    send_bit(1, 1);
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_frame_cnt", frame_cnt, m_frames % (1 << CNT_W));
    check("abort_sr", dut.sr, 0);
    reset = 1'b0;
    exp_q.delete();
    m_sr      = 2'b00;
    out_ready = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    send_bit(1, 1);
    drain();
    check("frame_cnt_d", frame_cnt, m_frames % (1 << CNT_W));

    // Back-to-back frames: only the tail cycles separate them
    do_reset();
    send_bit(1, 0);
    a = last_acc;
    send_bit(1, 1);
    b = last_acc;
    send_bit(0, 1);
    c = last_acc;
    check("b2b_in_frame", b - a, 1);
    check("b2b_frame_gap", c - b, GAP);
    drain();
    check("frame_cnt_b2b", frame_cnt, 2);

    // Counter wrap with single-bit frames
    do_reset();
    for (int i = 0; i < (1 << CNT_W) - 1; i++) begin
      send_bit(i[0], 1);
    end
    drain();
    check("frame_cnt_max", frame_cnt, (1 << CNT_W) - 1);
    send_bit(1, 1);
    drain();
    check("frame_cnt_wrap", frame_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
